avgp_3x3_ctrl: RTL and testbench

Frame sequencer for the 3x3 floating-point average-pool core. It consumes the per-pixel window stream from the window/line-buffer stage and counts the column and row of each window. It gates the core's `valid_in` so that only windows lying fully inside the image and on the stride grid are issued. It then tracks results returning from the core's add/div pipeline and signals frame completion. It sits between the window generator and `avgp_3x3_core`; pixel data bypasses it unchanged.

---
 rtl/avgp_pkg.sv | 22 ++
 rtl/avgp_pos_counter.sv | 48 ++++
 rtl/avgp_3x3_ctrl.sv | 128 ++++++++++++
 tb/tb_avgp_3x3_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avgp_pkg.sv
// Shared definitions for the 3x3 average-pool controllers: the frame state
// encoding, the expected-result-count calculation and the stride legality check.
package avgp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } avgp_state_t;

    // Number of 3x3 windows per frame that lie fully inside the image
    // and on the stride grid.
    function automatic int avgp_exp_count(input int w, input int h, input int s);
        return ((w - 3) / s + 1) * ((h - 3) / s + 1);
    endfunction

    function automatic bit avgp_stride_ok(input int s);
        return (s == 1) || (s == 2);
    endfunction

endpackage

// File: rtl/avgp_pos_counter.sv
// Raster position counter: tracks the column and row of the current pixel,
// advancing on enable, with a synchronous clear and a last-pixel flag.
module avgp_pos_counter
    import avgp_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 33,
    parameter int IMAGE_HEIGHT = 33,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_col,
    output logic [CNT_WIDTH-1:0] o_row,
    output logic                 o_last
);

    localparam logic [CNT_WIDTH-1:0] COL_MAX = CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_MAX = CNT_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_col;
    logic [CNT_WIDTH-1:0] r_row;

    // Column/row advance: column wraps at the row end and bumps the row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (r_col == COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == ROW_MAX) ? '0 : r_row + ONE;
            end else begin
                r_col <= r_col + ONE;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (r_col == COL_MAX) && (r_row == ROW_MAX);

endmodule

// File: rtl/avgp_3x3_ctrl.sv
// Frame sequencer for the 3x3 average-pool core: gates window valids onto the
// stride grid, counts returning results and pulses done at frame completion.
module avgp_3x3_ctrl
    import avgp_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 33,
    parameter int IMAGE_HEIGHT = 33,
    parameter int STRIDE       = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 win_valid,
    output logic                 core_valid_in,
    input  logic                 core_valid_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 overflow
);

    localparam int                   EXP   = avgp_exp_count(IMAGE_WIDTH, IMAGE_HEIGHT, STRIDE);
    localparam logic [CNT_WIDTH-1:0] EXP_C = CNT_WIDTH'(EXP);
    localparam logic [CNT_WIDTH-1:0] TWO   = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

    if (!avgp_stride_ok(STRIDE) || (IMAGE_WIDTH < 3) || (IMAGE_HEIGHT < 3) ||
        (longint'(EXP) >= (longint'(1) << CNT_WIDTH)) ||
        (longint'(IMAGE_WIDTH) > (longint'(1) << CNT_WIDTH)) ||
        (longint'(IMAGE_HEIGHT) > (longint'(1) << CNT_WIDTH))) begin : g_cfg_err
        $error("avgp_3x3_ctrl: illegal STRIDE/IMAGE size/CNT_WIDTH combination");
    end

    avgp_state_t          r_state;
    avgp_state_t          w_next;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic                 r_overflow;

    logic [CNT_WIDTH-1:0] w_col;
    logic [CNT_WIDTH-1:0] w_row;
    logic                 w_last;
    logic                 w_run;
    logic                 w_in_frame;
    logic                 w_start_acc;
    logic                 w_accept;
    logic                 w_col_ok;
    logic                 w_row_ok;
    logic                 w_at_exp;
    logic                 w_count_en;
    logic                 w_ovf_set;

    assign w_run       = (r_state == RUN);
    assign w_in_frame  = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_acc = start && (r_state == IDLE);
    assign w_accept    = win_valid && w_run;

    avgp_pos_counter #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_pos (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_start_acc),
        .i_en    (w_accept),
        .o_col   (w_col),
        .o_row   (w_row),
        .o_last  (w_last)
    );

    // With only strides 1 and 2 legal, (pos-2)%2==0 reduces to an even position.
    assign w_col_ok = (w_col >= TWO) && ((STRIDE == 1) || !w_col[0]);
    assign w_row_ok = (w_row >= TWO) && ((STRIDE == 1) || !w_row[0]);

    assign core_valid_in = w_accept && w_col_ok && w_row_ok;

    assign w_at_exp   = (r_out_count == EXP_C);
    assign w_count_en = core_valid_out && w_in_frame && !w_at_exp;
    assign w_ovf_set  = core_valid_out && (!w_in_frame || w_at_exp);

    // Frame state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; pixel completion and result completion are checked independently.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)    w_next = RUN;
            RUN:     if (w_accept && w_last) w_next = DRAIN;
            DRAIN:   if (w_at_exp) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result counter: cleared on frame start, held through IDLE afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_count <= '0;
        end else if (w_start_acc) begin
            r_out_count <= '0;
        end else if (w_count_en) begin
            r_out_count <= r_out_count + ONE;
        end
    end

    // Sticky flag for results arriving outside a frame or beyond the expected count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end
    end

    assign busy      = w_in_frame;
    assign done      = (r_state == DONE);
    assign out_count = r_out_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_avgp_3x3_ctrl.sv
// Self-checking bench for avgp_3x3_ctrl on a 5x5 image: one stride-1 and one
// stride-2 instance, each with its core pipeline modelled as a delay line.
module tb_avgp_3x3_ctrl;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start1, win1, cvi1, cvo1, busy1, done1, ovf1, inj1;
    logic [CW-1:0] cnt1;
    logic          start2, win2, cvi2, cvo2, busy2, done2, ovf2;
    logic [CW-1:0] cnt2;

    logic [19:0]   dly1;
    logic [2:0]    dly2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int iss2_cnt = 0;

    bit q1[$];
    bit q2[$];

    typedef struct {
        int gap;
        bit iss1;
        bit iss2;
    } vec_t;
    vec_t tbl[25];

    avgp_3x3_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .STRIDE       (1),
        .CNT_WIDTH    (CW)
    ) dut1 (
        .clk            (clk),
        .reset_n        (rst_n),
        .start          (start1),
        .win_valid      (win1),
        .core_valid_in  (cvi1),
        .core_valid_out (cvo1),
        .busy           (busy1),
        .done           (done1),
        .out_count      (cnt1),
        .overflow       (ovf1)
    );

    avgp_3x3_ctrl #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .STRIDE       (2),
        .CNT_WIDTH    (CW)
    ) dut2 (
        .clk            (clk),
        .reset_n        (rst_n),
        .start          (start2),
        .win_valid      (win2),
        .core_valid_in  (cvi2),
        .core_valid_out (cvo2),
        .busy           (busy2),
        .done           (done2),
        .out_count      (cnt2),
        .overflow       (ovf2)
    );

    // Core pipeline stand-ins, reset together with the controllers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly1 <= '0;
            dly2 <= '0;
        end else begin
            dly1 <= {dly1[18:0], cvi1};
            dly2 <= {dly2[1:0], cvi2};
        end
    end
    assign cvo1 = dly1[19] | inj1;
    assign cvo2 = dly2[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: each driven pixel queues its expected issue flag.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb1_underflow: got pixel with empty queue, expected none");
                end else begin
                    chk("issue1", cvi1, q1.pop_front());
                end
            end else begin
                chk("quiet1", cvi1, 0);
            end
            if (win2) begin
                if (q2.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb2_underflow: got pixel with empty queue, expected none");
                end else begin
                    chk("issue2", cvi2, q2.pop_front());
                end
            end else begin
                chk("quiet2", cvi2, 0);
            end
            if (cvi2) iss2_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic px1(input bit e, input int gap, input bit st);
        start1 = st;
        win1   = 1'b1;
        q1.push_back(e);
        step();
        start1 = 1'b0;
        win1   = 1'b0;
        repeat (gap) step();
    endtask

    task automatic px2(input bit e, input int gap);
        win2 = 1'b1;
        q2.push_back(e);
        step();
        win2 = 1'b0;
        repeat (gap) step();
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
    endtask

    task automatic frame1(input bit gaps, input int start_at, output int lastc);
        lastc = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 24) lastc = cyc;
            px1(tbl[k].iss1, gaps ? tbl[k].gap : 0, k == start_at);
        end
    endtask

    // Waits for done on the selected instance, checks its distance from the
    // last pixel's cycle and that it lasts exactly one cycle.
    task automatic wait_done(input bit sel, input string name, input int lastc, input int lat);
        int waited;
        waited = 0;
        while (!(sel ? done2 : done1) && waited < 200) begin
            step();
            waited++;
        end
        if (!(sel ? done2 : done1)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no done within 200 cycles, expected done", name);
        end else begin
            chk(name, cyc - lastc, lat);
            step();
            chk({name, "_width"}, sel ? done2 : done1, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, expected $finish");
        $fatal(1);
    end

    initial begin
        int lastc;

        for (int k = 0; k < 25; k++) begin
            int c;
            int r;
            c = k % W;
            r = k / W;
            tbl[k].gap  = int'($urandom_range(0, 2));
            tbl[k].iss1 = (c >= 2) && (r >= 2);
            tbl[k].iss2 = (c >= 2) && (r >= 2) && (c % 2 == 0) && (r % 2 == 0);
        end

        rst_n  = 1'b0;
        start1 = 1'b0;
        win1   = 1'b0;
        inj1   = 1'b0;
        start2 = 1'b0;
        win2   = 1'b0;
        repeat (3) step();
        chk("rst_cvi1",  cvi1,  0);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_cnt1",  cnt1,  0);
        chk("rst_ovf1",  ovf1,  0);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        chk("rst_cnt2",  cnt2,  0);
        chk("rst_ovf2",  ovf2,  0);
        rst_n = 1'b1;
        step();

        // Contiguous stride-1 frame; done lands 21 edges after the accepting edge.
        pulse_start1();
        chk("busy_rise", busy1, 1);
        chk("cnt_start", cnt1, 0);
        frame1(1'b0, -1, lastc);
        chk("busy_drain", busy1, 1);
        wait_done(1'b0, "done_lat_a", lastc, 22);
        chk("cnt_a",  cnt1,  9);
        chk("ovf_a",  ovf1,  0);
        chk("busy_a", busy1, 0);

        // Back-to-back frame started in the first IDLE cycle after DONE.
        pulse_start1();
        chk("cnt_restart", cnt1, 0);
        chk("busy_b2b", busy1, 1);
        frame1(1'b0, -1, lastc);
        wait_done(1'b0, "done_lat_b2b", lastc, 22);
        chk("cnt_b2b", cnt1, 9);

        // Pixels in IDLE are ignored; start during RUN and DRAIN is ignored.
        px1(1'b0, 0, 1'b0);
        px1(1'b0, 0, 1'b0);
        px1(1'b0, 0, 1'b0);
        chk("cnt_idle_hold", cnt1, 9);
        chk("busy_idle", busy1, 0);
        pulse_start1();
        frame1(1'b1, 12, lastc);
        pulse_start1();
        chk("busy_drain_start", busy1, 1);
        wait_done(1'b0, "done_lat_c", lastc, 22);
        chk("cnt_c", cnt1, 9);
        chk("ovf_c", ovf1, 0);

        // Stray result after done.
        inj1 = 1'b1;
        step();
        inj1 = 1'b0;
        chk("ovf_set", ovf1, 1);
        chk("cnt_hold_ovf", cnt1, 9);
        repeat (4) step();
        chk("ovf_sticky", ovf1, 1);

        // Asynchronous reset while pixel 13 (col 3, row 2) is being issued.
        pulse_start1();
        for (int k = 0; k < 13; k++) px1(tbl[k].iss1, 0, 1'b0);
        win1 = 1'b1;
        #1;
        chk("pre_rst_cvi", cvi1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_cvi",  cvi1,  0);
        chk("async_busy", busy1, 0);
        chk("async_done", done1, 0);
        chk("async_cnt",  cnt1,  0);
        chk("async_ovf",  ovf1,  0);
        win1 = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        pulse_start1();
        frame1(1'b0, -1, lastc);
        wait_done(1'b0, "done_lat_e", lastc, 22);
        chk("cnt_e", cnt1, 9);
        chk("ovf_e", ovf1, 0);

        // Stride-2 frame with gapped windows.
        iss2_cnt = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("busy2_rise", busy2, 1);
        lastc = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 24) lastc = cyc;
            px2(tbl[k].iss2, tbl[k].gap);
        end
        wait_done(1'b1, "done_lat_s2", lastc, 5);
        chk("cnt_s2",    cnt2,     4);
        chk("ovf_s2",    ovf2,     0);
        chk("issues_s2", iss2_cnt, 4);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
